// File: rtl/dcache_pkg.sv
// Shared geometry, state encoding and byte-lane helpers for the direct-mapped data cache.
package dcache_pkg;

  localparam int TAG_W   = 3;
  localparam int IDX_W   = 3;
  localparam int OFF_W   = 2;
  localparam int BLK_W   = 32;
  localparam int SETS    = 8;
  localparam int BYTE_W  = 8;
  localparam int ADDR_W  = TAG_W + IDX_W + OFF_W;
  localparam int MADDR_W = TAG_W + IDX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    FILL      = 2'd3
  } state_t;

  // Byte k of a block lives in bits [8k+7:8k].
  function automatic logic [BYTE_W-1:0] get_byte(input logic [BLK_W-1:0] blk,
                                                 input logic [OFF_W-1:0] off);
    logic [BYTE_W-1:0] b;
    case (off)
      2'd0:    b = blk[7:0];
      2'd1:    b = blk[15:8];
      2'd2:    b = blk[23:16];
      default: b = blk[31:24];
    endcase
    return b;
  endfunction

  function automatic logic [BLK_W-1:0] put_byte(input logic [BLK_W-1:0] blk,
                                                input logic [OFF_W-1:0] off,
                                                input logic [BYTE_W-1:0] b);
    logic [BLK_W-1:0] r;
    r = blk;
    case (off)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage: valid/dirty/tag/data per set, byte-write and block-fill ports,
// combinational read of the indexed line.
module dcache_array
  import dcache_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic [IDX_W-1:0]   idx,
  input  logic               byte_we,
  input  logic [OFF_W-1:0]   byte_off,
  input  logic [BYTE_W-1:0]  byte_data,
  input  logic               fill_we,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [BLK_W-1:0]   fill_data,
  output logic               line_valid,
  output logic               line_dirty,
  output logic [TAG_W-1:0]   line_tag,
  output logic [BLK_W-1:0]   line_data
);

  logic [SETS-1:0]  valid_q;
  logic [SETS-1:0]  dirty_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [BLK_W-1:0] data_q [SETS];

  // Only the status bits are reset; tag and data are meaningless while invalid.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (byte_we) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_we) begin
      tag_q[idx]  <= fill_tag;
      data_q[idx] <= fill_data;
    end else if (byte_we) begin
      data_q[idx] <= put_byte(data_q[idx], byte_off, byte_data);
    end
  end

  assign line_valid = valid_q[idx];
  assign line_dirty = dirty_q[idx];
  assign line_tag   = tag_q[idx];
  assign line_data  = data_q[idx];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back/write-allocate data cache: 8 sets x 4-byte blocks,
// zero-stall hits, BUSYWAIT stall on miss while the line is written back and refilled.
module data_cache
  import dcache_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic               READ,
  input  logic               WRITE,
  input  logic [ADDR_W-1:0]  ADDRESS,
  input  logic [BYTE_W-1:0]  WRITEDATA,
  output logic [BYTE_W-1:0]  READDATA,
  output logic               BUSYWAIT,
  output logic               MEM_READ,
  output logic               MEM_WRITE,
  output logic [MADDR_W-1:0] MEM_ADDRESS,
  output logic [BLK_W-1:0]   MEM_WRITEDATA,
  input  logic [BLK_W-1:0]   MEM_READDATA,
  input  logic               MEM_BUSYWAIT
);

  // Handshake: the CPU holds READ/WRITE (and ADDRESS/WRITEDATA) stable while
  // BUSYWAIT=1; the access completes at the first posedge where BUSYWAIT=0.
  // Memory side: MEM_READ/MEM_WRITE stay high until MEM_BUSYWAIT has been seen
  // high and then low; the block is exchanged at that falling-edge posedge.

  state_t state, state_next;
  logic   seen_busy;
  logic   mem_done;

  logic [MADDR_W-1:0] miss_blk;
  logic [BLK_W-1:0]   fetched_blk;

  logic [IDX_W-1:0]   idx;
  logic               byte_we;
  logic               fill_we;
  logic               line_valid;
  logic               line_dirty;
  logic [TAG_W-1:0]   line_tag;
  logic [BLK_W-1:0]   line_data;

  logic req_wr, req_rd, hit;

  // While a miss is in flight the line is addressed from the latched miss
  // address so a dropped or changed CPU request cannot corrupt the refill.
  assign idx    = (state == IDLE) ? ADDRESS[4:2] : miss_blk[IDX_W-1:0];
  assign req_wr = WRITE;
  assign req_rd = READ & ~WRITE;
  assign hit    = line_valid && (line_tag == ADDRESS[7:5]);

  assign mem_done = seen_busy && !MEM_BUSYWAIT;

  dcache_array u_array (
    .CLK        (CLK),
    .RESET      (RESET),
    .idx        (idx),
    .byte_we    (byte_we),
    .byte_off   (ADDRESS[1:0]),
    .byte_data  (WRITEDATA),
    .fill_we    (fill_we),
    .fill_tag   (miss_blk[MADDR_W-1:IDX_W]),
    .fill_data  (fetched_blk),
    .line_valid (line_valid),
    .line_dirty (line_dirty),
    .line_tag   (line_tag),
    .line_data  (line_data)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      seen_busy <= 1'b0;
    end else begin
      state <= state_next;
      if (state == WRITEBACK || state == FETCH) begin
        seen_busy <= mem_done ? 1'b0 : (seen_busy | MEM_BUSYWAIT);
      end else begin
        seen_busy <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (state == IDLE) begin
      miss_blk <= ADDRESS[7:2];
    end
    if (state == FETCH && mem_done) begin
      fetched_blk <= MEM_READDATA;
    end
  end

  always_comb begin
    state_next    = state;
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    READDATA      = '0;
    byte_we       = 1'b0;
    fill_we       = 1'b0;
    case (state)
      IDLE: begin
        if (req_rd || req_wr) begin
          if (hit) begin
            if (req_wr) begin
              byte_we = 1'b1;
            end else begin
              READDATA = get_byte(line_data, ADDRESS[1:0]);
            end
          end else begin
            BUSYWAIT   = 1'b1;
            state_next = (line_valid && line_dirty) ? WRITEBACK : FETCH;
          end
        end
      end
      WRITEBACK: begin
        BUSYWAIT      = 1'b1;
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {line_tag, miss_blk[IDX_W-1:0]};
        MEM_WRITEDATA = line_data;
        if (mem_done) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = miss_blk;
        if (mem_done) begin
          state_next = FILL;
        end
      end
      FILL: begin
        BUSYWAIT   = 1'b1;
        fill_we    = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: CPU driver, reactive block memory, and
// scoreboards for load bytes and memory transactions.
module tb_data_cache;

  logic        CLK;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  int cmp_cnt = 0;
  int err_cnt = 0;

  logic [7:0]  exp_q[$];
  logic [38:0] exp_mem_q[$];

  logic [31:0] mem [64];
  int mem_pre = 0;
  int mem_lat = 5;

  data_cache dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  // Clock and watchdog
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: optional leading idle cycles, then mem_lat busy cycles,
  // then busy drops and the block is exchanged. Also checks each request.
  initial begin : mem_model
    int          pre_cnt;
    int          busy_cnt;
    logic        active;
    logic        act_wr;
    logic [5:0]  act_addr;
    logic [31:0] act_wdata;
    logic [38:0] exp_t;
    MEM_BUSYWAIT = 1'b0;
    MEM_READDATA = 32'h0;
    active       = 1'b0;
    pre_cnt      = 0;
    busy_cnt     = 0;
    act_wr       = 1'b0;
    act_addr     = 6'h0;
    act_wdata    = 32'h0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        active       = 1'b0;
        MEM_BUSYWAIT = 1'b0;
      end else begin
        if (!active && (MEM_READ || MEM_WRITE)) begin
          active       = 1'b1;
          act_wr       = MEM_WRITE;
          act_addr     = MEM_ADDRESS;
          act_wdata    = MEM_WRITEDATA;
          pre_cnt      = mem_pre;
          busy_cnt     = mem_lat;
          MEM_READDATA = 32'hDEADBEEF;
          check("mem_rd_wr_exclusive", {63'h0, MEM_READ & MEM_WRITE}, 64'h0);
          if (exp_mem_q.size() == 0) begin
            check("mem_unexpected_req", {25'h0, act_wr, act_addr, act_wdata}, 64'h0);
          end else begin
            exp_t = exp_mem_q.pop_front();
            check("mem_req", {25'h0, act_wr, act_addr, act_wr ? act_wdata : 32'h0},
                  {25'h0, exp_t});
          end
        end
        if (active) begin
          if (pre_cnt > 0) begin
            pre_cnt--;
          end else if (busy_cnt > 0) begin
            MEM_BUSYWAIT = 1'b1;
            busy_cnt--;
          end else begin
            MEM_BUSYWAIT = 1'b0;
            if (act_wr) mem[act_addr] = act_wdata;
            else        MEM_READDATA = mem[act_addr];
            active = 1'b0;
          end
        end
      end
    end
  end

  // Load-byte monitor: a pure read completes on a cycle with BUSYWAIT low.
  always @(negedge CLK) begin
    if (!RESET && READ && !WRITE && !BUSYWAIT) begin
      if (exp_q.size() == 0) begin
        check("cpu_unexpected_load", {56'h0, READDATA}, 64'h0);
      end else begin
        check("cpu_load", {56'h0, READDATA}, {56'h0, exp_q.pop_front()});
      end
    end
  end

  // One CPU access, held until BUSYWAIT is low; stall cycles are checked.
  task automatic cpu_op(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] d, input int exp_stalls, input string name);
    int stalls;
    stalls = 0;
    @(posedge CLK);
    #1;
    READ      = rd;
    WRITE     = wr;
    ADDRESS   = a;
    WRITEDATA = d;
    forever begin
      @(negedge CLK);
      if (!BUSYWAIT || stalls > 500) break;
      stalls++;
    end
    check(name, 64'(stalls), 64'(exp_stalls));
    @(posedge CLK);
    #1;
    READ  = 1'b0;
    WRITE = 1'b0;
  endtask

  function automatic logic [38:0] mrd(input logic [5:0] a);
    return {1'b0, a, 32'h0};
  endfunction

  function automatic logic [38:0] mwr(input logic [5:0] a, input logic [31:0] d);
    return {1'b1, a, d};
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'(i) * 32'h01010101;
    mem[6'h09] = 32'hDDCCBBAA;
    mem[6'h29] = 32'h44332211;
    mem[6'h02] = 32'h87654321;
    RESET     = 1'b1;
    READ      = 1'b0;
    WRITE     = 1'b0;
    ADDRESS   = 8'h0;
    WRITEDATA = 8'h0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_busywait",  {63'h0, BUSYWAIT},  64'h0);
    check("rst_mem_read",  {63'h0, MEM_READ},  64'h0);
    check("rst_mem_write", {63'h0, MEM_WRITE}, 64'h0);
    check("rst_mem_addr",  {58'h0, MEM_ADDRESS},   64'h0);
    check("rst_mem_wdata", {32'h0, MEM_WRITEDATA}, 64'h0);
    check("rst_readdata",  {56'h0, READDATA},      64'h0);

    // Cold read miss, 5-cycle memory
    mem_pre = 0; mem_lat = 5;
    exp_mem_q.push_back(mrd(6'h09));
    exp_q.push_back(8'hBB);
    cpu_op(1'b1, 1'b0, 8'h25, 8'h00, 8, "t1_read_miss_stalls");

    // Write hit then read hit, no stalls
    cpu_op(1'b0, 1'b1, 8'h25, 8'h5A, 0, "t2_write_hit_stalls");
    exp_q.push_back(8'h5A);
    cpu_op(1'b1, 1'b0, 8'h25, 8'h00, 0, "t2_read_hit_stalls");

    // Conflict miss on a dirty line: write-back then fetch
    mem_lat = 3;
    exp_mem_q.push_back(mwr(6'h09, 32'hDDCC5AAA));
    exp_mem_q.push_back(mrd(6'h29));
    exp_q.push_back(8'h22);
    cpu_op(1'b1, 1'b0, 8'hA5, 8'h00, 10, "t3_dirty_miss_stalls");

    // Reset in the middle of a fetch
    mem_lat = 4;
    exp_mem_q.push_back(mrd(6'h09));
    @(posedge CLK);
    #1;
    READ = 1'b1; ADDRESS = 8'h25;
    repeat (3) @(negedge CLK);
    check("t4_fetch_active", {63'h0, MEM_READ}, 64'h1);
    @(posedge CLK);
    #1;
    RESET = 1'b1; READ = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    check("t4_mem_read_after_rst", {63'h0, MEM_READ}, 64'h0);
    check("t4_busywait_after_rst", {63'h0, BUSYWAIT}, 64'h0);
    exp_mem_q.push_back(mrd(6'h09));
    exp_q.push_back(8'h5A);
    cpu_op(1'b1, 1'b0, 8'h25, 8'h00, 7, "t4_refetch_stalls");

    // Memory idle for 2 cycles before raising busy: capture only after 1->0
    mem_pre = 2; mem_lat = 3;
    exp_mem_q.push_back(mrd(6'h02));
    exp_q.push_back(8'h87);
    cpu_op(1'b1, 1'b0, 8'h0B, 8'h00, 8, "t5_late_busy_stalls");

    // READ and WRITE together act as a store
    mem_pre = 0; mem_lat = 2;
    cpu_op(1'b1, 1'b1, 8'h25, 8'h11, 0, "t6_rw_store_stalls");
    exp_q.push_back(8'h11);
    cpu_op(1'b1, 1'b0, 8'h25, 8'h00, 0, "t6_read_back_stalls");
    exp_mem_q.push_back(mwr(6'h09, 32'hDDCC11AA));
    exp_mem_q.push_back(mrd(6'h29));
    exp_q.push_back(8'h22);
    cpu_op(1'b1, 1'b0, 8'hA5, 8'h00, 8, "t6_dirty_evict_stalls");

    // Write miss allocates a dirty line, later evicted
    exp_mem_q.push_back(mrd(6'h03));
    cpu_op(1'b0, 1'b1, 8'h0C, 8'h77, 5, "t7_write_miss_stalls");
    exp_q.push_back(8'h77);
    cpu_op(1'b1, 1'b0, 8'h0C, 8'h00, 0, "t7_read_alloc_stalls");
    exp_mem_q.push_back(mwr(6'h03, 32'h03030377));
    exp_mem_q.push_back(mrd(6'h0B));
    exp_q.push_back(8'h0B);
    cpu_op(1'b1, 1'b0, 8'h2C, 8'h00, 8, "t7_evict_stalls");

    repeat (4) @(negedge CLK);
    check("cpu_queue_drained", 64'(exp_q.size()), 64'h0);
    check("mem_queue_drained", 64'(exp_mem_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
